// File: rtl/instruction_queue_pkg.sv
// Shared types and helpers for the dual-issue instruction queue.
// Entry layout is {data, address}; the RAM stores entries in exactly this packing.
package instr_queue_pkg;

    localparam int IQ_DATA_WIDTH = 32;
    localparam int IQ_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [IQ_DATA_WIDTH-1:0] data;
        logic [IQ_ADDR_WIDTH-1:0] address;
    } iq_entry_t;

    // Clamp a 0..2 pop request to the entries actually present (avail already capped at 2).
    function automatic logic [1:0] sat_sub2(input logic [1:0] req, input logic [1:0] avail);
        return (req > avail) ? avail : req;
    endfunction

endpackage

// File: rtl/instruction_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue; master drives push/pop, slave is the queue.
// Status outputs are combinational from queue state, no same-cycle bypass.
interface instruction_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  write_en1;
    logic                  write_en2;
    logic [DATA_WIDTH-1:0] write_data1;
    logic [ADDR_WIDTH-1:0] write_address1;
    logic [DATA_WIDTH-1:0] write_data2;
    logic [ADDR_WIDTH-1:0] write_address2;
    logic                  read_en1;
    logic                  read_en2;
    logic [DATA_WIDTH-1:0] data_out1;
    logic [ADDR_WIDTH-1:0] address_out1;
    logic [DATA_WIDTH-1:0] data_out2;
    logic [ADDR_WIDTH-1:0] address_out2;
    logic                  valid_out1;
    logic                  valid_out2;
    logic [CNT_W-1:0]      count;
    logic                  empty;
    logic                  almost_empty;
    logic                  full;

    modport master (
        output flush, write_en1, write_en2, write_data1, write_address1,
               write_data2, write_address2, read_en1, read_en2,
        input  data_out1, address_out1, data_out2, address_out2,
               valid_out1, valid_out2, count, empty, almost_empty, full
    );

    modport slave (
        input  flush, write_en1, write_en2, write_data1, write_address1,
               write_data2, write_address2, read_en1, read_en2,
        output data_out1, address_out1, data_out2, address_out2,
               valid_out1, valid_out2, count, empty, almost_empty, full
    );

endinterface

// File: rtl/instruction_queue_ram.sv
// DEPTH-entry register array, two write ports (wp, wp+1) and two async read ports (rp, rp+1).
// Storage is never reset; the controller gates writes so rejected pushes leave it untouched.
module instruction_queue_ram #(
    parameter  int ENTRY_W = 64,
    parameter  int DEPTH   = 16,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we1,
    input  logic               we2,
    input  logic [PTR_W-1:0]   wp,
    input  logic [ENTRY_W-1:0] wdat1,
    input  logic [ENTRY_W-1:0] wdat2,
    input  logic [PTR_W-1:0]   rp,
    output logic [ENTRY_W-1:0] rdat1,
    output logic [ENTRY_W-1:0] rdat2
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wp_nxt;
    logic [PTR_W-1:0]   rp_nxt;

    // Pointer width equals log2(DEPTH), so +1 wraps naturally.
    assign wp_nxt = wp + PTR_W'(1);
    assign rp_nxt = rp + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (we1) mem[wp]     <= wdat1;
        if (we2) mem[wp_nxt] <= wdat2;
    end

    assign rdat1 = mem[rp];
    assign rdat2 = mem[rp_nxt];

endmodule

// File: rtl/instruction_queue.sv
// Dual-issue fetch->decode instruction queue: 0-2 pushes and 0-2 pops per cycle, two oldest entries shown combinationally.
// A push pair that does not fit in pre-edge free space is dropped whole; pops clamp to occupancy; flush empties.
module instruction_queue
    import instr_queue_pkg::*;
#(
    parameter  int DATA_WIDTH = IQ_DATA_WIDTH,
    parameter  int ADDR_WIDTH = IQ_ADDR_WIDTH,
    parameter  int DEPTH      = 16,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    instruction_queue_if.slave iq
);

    localparam int               ENTRY_W = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (((1 << PTR_W) != DEPTH) || (DEPTH < 4)) begin : g_depth_check
        $error("instruction_queue: DEPTH must be a power of two and at least 4");
    end

    logic [PTR_W-1:0]   write_pointer;
    logic [PTR_W-1:0]   read_pointer;
    logic [CNT_W-1:0]   count_q;

    logic [1:0]         wr_req;
    logic [1:0]         rd_req;
    logic [1:0]         wr_acc;
    logic [1:0]         rd_acc;
    logic [1:0]         avail;
    logic [CNT_W-1:0]   free_slots;
    logic [CNT_W:0]     count_next;

    logic               ram_we1;
    logic               ram_we2;
    logic [ENTRY_W-1:0] ram_wdat1;
    logic [ENTRY_W-1:0] ram_wdat2;
    logic [ENTRY_W-1:0] ram_rdat1;
    logic [ENTRY_W-1:0] ram_rdat2;

    always_comb begin
        wr_req     = iq.write_en1 ? (iq.write_en2 ? 2'd2 : 2'd1) : 2'd0;
        rd_req     = iq.read_en1  ? (iq.read_en2  ? 2'd2 : 2'd1) : 2'd0;
        // Space is judged on the pre-edge count; a same-cycle pop does not make room.
        free_slots = DEPTH_C - count_q;
        wr_acc     = (CNT_W'(wr_req) <= free_slots) ? wr_req : 2'd0;
        avail      = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
        rd_acc     = sat_sub2(rd_req, avail);
        count_next = {1'b0, count_q} + (CNT_W+1)'(wr_acc) - (CNT_W+1)'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            count_q       <= '0;
        end else if (iq.flush) begin
            write_pointer <= '0;
            read_pointer  <= '0;
            count_q       <= '0;
        end else begin
            write_pointer <= write_pointer + PTR_W'(wr_acc);
            read_pointer  <= read_pointer  + PTR_W'(rd_acc);
            count_q       <= count_next[CNT_W-1:0];
        end
    end

    assign ram_we1   = !rst && !iq.flush && (wr_acc != 2'd0);
    assign ram_we2   = !rst && !iq.flush && (wr_acc == 2'd2);
    assign ram_wdat1 = {iq.write_data1, iq.write_address1};
    assign ram_wdat2 = {iq.write_data2, iq.write_address2};

    instruction_queue_ram #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we1   (ram_we1),
        .we2   (ram_we2),
        .wp    (write_pointer),
        .wdat1 (ram_wdat1),
        .wdat2 (ram_wdat2),
        .rp    (read_pointer),
        .rdat1 (ram_rdat1),
        .rdat2 (ram_rdat2)
    );

    assign iq.data_out1    = ram_rdat1[ENTRY_W-1:ADDR_WIDTH];
    assign iq.address_out1 = ram_rdat1[ADDR_WIDTH-1:0];
    assign iq.data_out2    = ram_rdat2[ENTRY_W-1:ADDR_WIDTH];
    assign iq.address_out2 = ram_rdat2[ADDR_WIDTH-1:0];

    assign iq.count        = count_q;
    assign iq.valid_out1   = (count_q != '0);
    assign iq.valid_out2   = (count_q >= CNT_W'(2));
    assign iq.empty        = (count_q == '0);
    assign iq.almost_empty = (count_q == CNT_W'(1));
    // Fetch delivers pairs, so "full" means a pair no longer fits.
    assign iq.full         = (free_slots < CNT_W'(2));

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Parametrised dual-issue instruction queue between the fetch stage and the decode/issue stage.
- Accepts 0, 1 or 2 instruction/PC pairs per cycle and presents the two oldest entries combinationally.
- Generalised in depth and width over the current FIFO. Adds correct simultaneous read/write occupancy accounting, an occupancy count output, per-slot valid flags, read clamping, overflow protection, and a pipeline flush.

Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC width stored alongside each instruction
- DEPTH, 16, number of entries; power of two, at least 4
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden
- CNT_W, $clog2(DEPTH)+1, count width; derived, not overridden

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries (branch mispredict / exception)
- write_en1  in  1  push slot 1
- write_en2  in  1  push slot 2; honoured only together with write_en1
- write_data1  in  DATA_WIDTH  instruction for slot 1
- write_address1  in  ADDR_WIDTH  PC for slot 1
- write_data2  in  DATA_WIDTH  instruction for slot 2
- write_address2  in  ADDR_WIDTH  PC for slot 2
- read_en1  in  1  pop oldest entry
- read_en2  in  1  pop second entry; honoured only together with read_en1
- data_out1  out  DATA_WIDTH  oldest instruction
- address_out1  out  ADDR_WIDTH  oldest PC
- data_out2  out  DATA_WIDTH  second-oldest instruction
- address_out2  out  ADDR_WIDTH  second-oldest PC
- valid_out1  out  1  count >= 1
- valid_out2  out  1  count >= 2
- count  out  CNT_W  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- almost_empty  out  1  count == 1
- full  out  1  DEPTH - count < 2, i.e. a pair cannot be accepted

Behaviour:
- Reset (rst high at an edge):
  - write_pointer, read_pointer and count go to 0.
  - Next cycle: empty=1, almost_empty=0, full=0, valid_out1=0, valid_out2=0.
  - Storage contents are not reset; data and address outputs are don't-care while the matching valid is 0.
- Effective requests:
  - wr_req = write_en1 + (write_en1 & write_en2).
  - rd_req = read_en1 + (read_en1 & read_en2).
- Write acceptance:
  - If wr_req > DEPTH - count, the whole write is dropped. There is no partial write and no error flag.
  - Producers must honour full.
  - Free space is evaluated on pre-edge count; same-cycle reads do not create space.
- Read clamping: rd_acc = min(rd_req, count). Popping an empty or single-entry queue never underflows.
- Same-cycle read and write:
  - count_next = count + wr_acc - rd_acc, computed at CNT_W+1 bits.
  - All nine combinations of wr_acc in {0,1,2} and rd_acc in {0,1,2} must be exact.
- Pointer updates:
  - write_pointer += wr_acc and read_pointer += rd_acc, modulo DEPTH (natural PTR_W wrap).
  - Slot 2 is written at write_pointer+1 mod DEPTH; data_out2 is read from read_pointer+1 mod DEPTH.
- Read latency:
  - Outputs are combinational from read_pointer and storage.
  - An entry written at edge N is visible on data_out1/data_out2 after edge N.
  - There is no same-cycle write-to-read bypass.
- Flush:
  - flush high at an edge sets both pointers and count to 0.
  - Writes presented in the same cycle are discarded.
  - Priority: rst > flush > normal operation.
- Storage write:
  - Gated by rst=0, flush=0 and acceptance.
  - Rejected writes never modify storage.
- The full definition (fewer than 2 free slots) is intentional: fetch always delivers pairs.

Decomposition:
- Shared package instr_queue_pkg:
  - typedef iq_entry_t, a packed struct {data, address} at DATA_WIDTH+ADDR_WIDTH.
  - helper function sat_sub2(req, avail) for read clamping.
- One natural sub-module, instruction_queue_ram: DEPTH-entry register array with 2 write ports (addresses wp, wp+1) and 2 asynchronous read ports (rp, rp+1).
- All control (pointers, count, acceptance, flush) stays in instruction_queue.

Test Plan:
- Reset then idle:
  - Expect count=0, empty=1, full=0, valid_out1=0.
  - Assert read_en1=read_en2=1 for 3 cycles; count stays 0 and pointers are unchanged.
- Dual push then simultaneous 2-in/1-out:
  - Write pairs (0xA0,0x100),(0xA1,0x104); count=2, data_out1=0xA0, data_out2=0xA1.
  - Next cycle write pair (0xA2,0xA3) with read_en1 only; count=3, data_out1=0xA1.
- Fill to DEPTH-1=15 with single writes:
  - full=1.
  - A dual write is dropped: count stays 15 and storage is unchanged.
  - A single read then gives count=14 and full=0.
- Wrap-around:
  - Stream 40 sequential instructions (data = index) with mixed 1/2 writes and 1/2 reads, keeping occupancy between 2 and 12.
  - Scoreboard: outputs appear in exact order 0..39, address = 0x1000+4*index, with no duplicates or losses.
- Read clamp:
  - With count=1 (data 0x55), assert read_en1=read_en2=1.
  - Expect valid_out2=0 before the edge; count=0 and empty=1 after.
- Flush mid-operation:
  - With count=9, assert flush together with a dual write.
  - Next cycle count=0 and empty=1; a subsequent single write of 0x77 appears on data_out1 with count=1.
  - Repeat with rst asserted: same result.
